// File: rtl/frame_buffer_scheduler_if.sv
// frame_buffer_scheduler_if: bundle of rasterizer, DVI scan-out, RAM and swap signals.
// Ports (signals):
//   rast_pixel_rdy/rast_width/rast_height/rast_color_input  rasterizer write request
//   read_rast_pixel_rdy                                       write accept strobe
//   next_frame_switch                                         swap request pulse
//   dvi_fifo_full/dvi_color_out/dvi_fifo_write_enable         scan-out FIFO side
//   mem_addr/mem_we/mem_wdata/mem_rdata                       single-port RAM
//   front_bank                                                bank being scanned out
// Modports: master = environment (rasterizer, FIFO, RAM), slave = scheduler.
interface frame_buffer_scheduler_if;
    logic       rast_pixel_rdy;
    logic [9:0] rast_width;
    logic [8:0] rast_height;
    logic [2:0] rast_color_input;
    logic       read_rast_pixel_rdy;
    logic       next_frame_switch;
    logic       dvi_fifo_full;
    logic [2:0] dvi_color_out;
    logic       dvi_fifo_write_enable;
    logic [19:0] mem_addr;
    logic       mem_we;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;
    logic       front_bank;

    modport master (
        output rast_pixel_rdy, rast_width, rast_height, rast_color_input,
        output next_frame_switch, dvi_fifo_full, mem_rdata,
        input  read_rast_pixel_rdy, dvi_color_out, dvi_fifo_write_enable,
        input  mem_addr, mem_we, mem_wdata, front_bank
    );

    modport slave (
        input  rast_pixel_rdy, rast_width, rast_height, rast_color_input,
        input  next_frame_switch, dvi_fifo_full, mem_rdata,
        output read_rast_pixel_rdy, dvi_color_out, dvi_fifo_write_enable,
        output mem_addr, mem_we, mem_wdata, front_bank
    );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler: shares one single-port frame-buffer RAM between DVI
// scan-out reads and rasterizer writes, with a double-buffered frame swap.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-high reset
//   bus  frame_buffer_scheduler_if.slave (rasterizer, DVI FIFO, RAM, swap)
module frame_buffer_scheduler #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input logic clk,
    input logic rst,
    frame_buffer_scheduler_if.slave bus
);
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int AW = 19;
    localparam logic [XW-1:0] X_MAX = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_PIXELS - 1);
    localparam logic [AW-1:0] LINE  = AW'(H_PIXELS);

    typedef enum logic {RUN, SWAP_PEND} state_t;

    state_t        state, state_next;
    logic          front_bank, front_bank_next;
    logic [XW-1:0] scan_x, scan_x_next;
    logic [YW-1:0] scan_y, scan_y_next;
    logic          last_wr, last_wr_next;
    logic          in_flight, in_flight_next;
    logic          rd_req, wr_req, rd_grant, wr_grant, in_range, last_pixel;
    logic [AW-1:0] rd_addr, wr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            front_bank <= 1'b0;
            scan_x     <= '0;
            scan_y     <= '0;
            last_wr    <= 1'b1;
            in_flight  <= 1'b0;
        end else begin
            state      <= state_next;
            front_bank <= front_bank_next;
            scan_x     <= scan_x_next;
            scan_y     <= scan_y_next;
            last_wr    <= last_wr_next;
            in_flight  <= in_flight_next;
        end
    end

    always_comb begin
        rd_req     = !bus.dvi_fifo_full;
        wr_req     = bus.rast_pixel_rdy && state == RUN;
        // on contention the requester that lost last time wins
        rd_grant   = rd_req && (!wr_req || last_wr);
        wr_grant   = wr_req && !rd_grant;
        in_range   = bus.rast_width <= X_MAX && bus.rast_height <= Y_MAX;
        last_pixel = scan_x == X_MAX && scan_y == Y_MAX;
        rd_addr    = AW'(scan_y) * LINE + AW'(scan_x);
        wr_addr    = AW'(bus.rast_height) * LINE + AW'(bus.rast_width);
        state_next      = state;
        front_bank_next = front_bank;
        scan_x_next     = scan_x;
        scan_y_next     = scan_y;
        last_wr_next    = rd_req && wr_req ? wr_grant : last_wr;
        in_flight_next  = rd_grant;
        if (rd_grant) begin
            scan_x_next = scan_x == X_MAX ? '0 : scan_x + 1'b1;
            scan_y_next = scan_x != X_MAX ? scan_y : scan_y == Y_MAX ? '0 : scan_y + 1'b1;
        end
        if (state == RUN && bus.next_frame_switch)
            state_next = SWAP_PEND;
        // swap once the final pixel of the front frame has been read
        if (state == SWAP_PEND && rd_grant && last_pixel) begin
            state_next      = RUN;
            front_bank_next = !front_bank;
        end
        bus.read_rast_pixel_rdy   = !rst && wr_grant;
        bus.mem_we                = !rst && wr_grant && in_range;
        bus.mem_wdata             = !rst && wr_grant ? bus.rast_color_input : '0;
        bus.mem_addr              = rst ? '0 : rd_grant ? {front_bank, rd_addr} :
                                    wr_grant ? {!front_bank, wr_addr} : '0;
        bus.dvi_fifo_write_enable = !rst && in_flight;
        bus.dvi_color_out         = !rst && in_flight ? bus.mem_rdata : '0;
        bus.front_bank            = front_bank;
    end
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb_frame_buffer_scheduler: directed stimulus with an event scoreboard for frame_buffer_scheduler.
module tb_frame_buffer_scheduler;
    localparam int H = 640;
    localparam int V = 4;
    localparam int N = H * V;

    typedef struct {
        bit         wr;
        logic [19:0] addr;
        logic       we;
        logic [2:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    frame_buffer_scheduler_if bus();
    frame_buffer_scheduler #(.H_PIXELS(H), .V_PIXELS(V)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [2:0] ram [0:8191];
    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int scan = 0;
    logic fb = 1'b0;

    function automatic logic [2:0] pat(input logic [19:0] a);
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ {2'b00, a[19]};
    endfunction

    function automatic int idx(input logic [19:0] a);
        return int'({a[19], a[11:0]});
    endfunction

    always @(posedge clk) begin
        bus.mem_rdata <= ram[idx(bus.mem_addr)];
        if (bus.mem_we) ram[idx(bus.mem_addr)] <= bus.mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rast(input logic rdy, input int x, input int y, input logic [2:0] c);
        bus.rast_pixel_rdy   = rdy;
        bus.rast_width       = 10'(x);
        bus.rast_height      = 9'(y);
        bus.rast_color_input = c;
    endtask

    task automatic rd();
        logic [19:0] a;
        a = {fb, 19'(scan)};
        exp_q.push_back('{1'b0, a, 1'b0, pat(a)});
        scan = (scan + 1) % N;
        step();
    endtask

    task automatic wr(input logic [19:0] a, input logic we, input logic [2:0] d);
        exp_q.push_back('{1'b1, a, we, d});
        step();
    endtask

    initial begin : monitor
        logic pv, p_wr, p_we, ok;
        logic [19:0] p_addr;
        logic [2:0] p_data, got;
        ev_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if ({bus.dvi_fifo_write_enable, bus.dvi_color_out, bus.mem_we,
                     bus.read_rast_pixel_rdy, bus.mem_addr, bus.mem_wdata} != '0) begin
                    errors++;
                    $display("FAIL reset_outputs got fwe=%0b color=%0d we=%0b rrdy=%0b addr=%h wdata=%0d required all 0",
                             bus.dvi_fifo_write_enable, bus.dvi_color_out, bus.mem_we,
                             bus.read_rast_pixel_rdy, bus.mem_addr, bus.mem_wdata);
                end
                pv = 1'b0;
            end else begin
                if (pv && (p_wr || bus.dvi_fifo_write_enable)) begin
                    checks++;
                    got = p_wr ? p_data : bus.dvi_color_out;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event got wr=%0b addr=%h we=%0b data=%0d required none",
                                 p_wr, p_addr, p_we, got);
                    end else begin
                        e = exp_q.pop_front();
                        ok = p_wr ? e.wr && p_we == e.we && !bus.dvi_fifo_write_enable &&
                                    (!e.we || (p_addr == e.addr && p_data == e.data))
                                  : !e.wr && p_addr == e.addr && bus.dvi_color_out == e.data;
                        if (!ok) begin
                            errors++;
                            $display("FAIL event got wr=%0b addr=%h we=%0b data=%0d fwe=%0b required wr=%0b addr=%h we=%0b data=%0d",
                                     p_wr, p_addr, p_we, got, bus.dvi_fifo_write_enable,
                                     e.wr, e.addr, e.we, e.data);
                        end
                    end
                end else if (!pv && bus.dvi_fifo_write_enable) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_fifo_write got fwe=1 required 0");
                end
                pv     = 1'b1;
                p_wr   = bus.read_rast_pixel_rdy;
                p_we   = bus.mem_we;
                p_addr = bus.mem_addr;
                p_data = bus.mem_wdata;
            end
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = pat({i[12], 7'd0, i[11:0]});
        bus.next_frame_switch = 1'b0;
        bus.dvi_fifo_full = 1'b0;
        rast(1, 5, 2, 3'd5);
        repeat (3) step();
        rst = 1'b0;
        rast(0, 0, 0, 3'd0);
        repeat (20) rd();
        rast(1, 5, 2, pat(20'h80505));
        rd(); wr(20'h80505, 1, pat(20'h80505));
        rd(); wr(20'h80505, 1, pat(20'h80505));
        bus.dvi_fifo_full = 1'b1;
        rast(1, 0, 0, pat(20'h80000));     wr(20'h80000, 1, pat(20'h80000));
        rast(1, 639, 3, pat(20'h809FF));   wr(20'h809FF, 1, pat(20'h809FF));
        rast(1, 100, 1, pat(20'h802E4));   wr(20'h802E4, 1, pat(20'h802E4));
        rast(1, 639, 0, pat(20'h8027F));   wr(20'h8027F, 1, pat(20'h8027F));
        rast(1, 640, 0, 3'd7);             wr(20'h00000, 0, 3'd7);
        rast(1, 0, 4, 3'd7);               wr(20'h00000, 0, 3'd7);
        bus.dvi_fifo_full = 1'b0;
        rast(0, 0, 0, 3'd0);
        repeat (3) rd();
        bus.dvi_fifo_full = 1'b1;
        step();
        bus.dvi_fifo_full = 1'b0;
        rd();
        bus.next_frame_switch = 1'b1;
        rd();
        bus.next_frame_switch = 1'b0;
        rast(1, 1, 1, pat(20'h00281));
        do rd(); while (scan != 0);
        fb = 1'b1;
        repeat (2) begin rd(); wr(20'h00281, 1, pat(20'h00281)); end
        rast(0, 0, 0, 3'd0);
        while (scan != N - 1) rd();
        bus.next_frame_switch = 1'b1;
        rd();
        bus.next_frame_switch = 1'b0;
        rast(1, 1, 1, pat(20'h80281));
        do begin
            bus.next_frame_switch = scan == 100;
            rd();
        end while (scan != 0);
        bus.next_frame_switch = 1'b0;
        fb = 1'b0;
        repeat (2) begin rd(); wr(20'h80281, 1, pat(20'h80281)); end
        rast(0, 0, 0, 3'd0);
        repeat (3) rd();
        step();
        rst = 1'b1;
        rast(1, 5, 2, 3'd5);
        repeat (2) step();
        rst = 1'b0;
        rast(0, 0, 0, 3'd0);
        bus.dvi_fifo_full = 1'b1;
        scan = 0;
        fb = 1'b0;
        repeat (3) step();
        bus.dvi_fifo_full = 1'b0;
        repeat (3) rd();
        bus.dvi_fifo_full = 1'b1;
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d remaining required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
